// File: rtl/prbs_rx_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : prbs_rx_checker
//  Purpose  : Receive-side checker for a single-bit PRBS-7 (x^7+x^6+1) test
//             stream. Synchronises the incoming bit, self-aligns a local
//             PRBS-7 reference, declares lock, then counts bit errors and
//             drops lock when too many errors land in one window.
//  Ports    : clk      - system clock (PLL global clock)
//             rst_n    - asynchronous active-low reset (PLL LOCK)
//             data_in  - serial test bit, asynchronous to clk
//             en       - bit strobe, one received bit per clk with en=1
//             clr_cnt  - synchronous clear of err_cnt / bit_cnt
//             locked   - checker aligned to the stream (registered)
//             bit_err  - one-cycle pulse per mismatched bit while locked
//             err_cnt  - saturating count of errors seen while locked
//             bit_cnt  - saturating count of bits checked while locked
//  Revision : 1.0 - initial release
// ============================================================================
module prbs_rx_checker #(
   parameter int SYNC_BITS = 32,
   parameter int ERR_LIMIT = 8,
   parameter int WINDOW    = 256,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             data_in,
   input  logic             en,
   input  logic             clr_cnt,
   output logic             locked,
   output logic             bit_err,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] bit_cnt
);

   localparam int c_pos_w  = $clog2(WINDOW);
   localparam int c_werr_w = $clog2(ERR_LIMIT + 1);

   localparam logic [7:0]          c_sync_bits = 8'(SYNC_BITS);
   localparam logic [c_werr_w-1:0] c_err_limit = c_werr_w'(ERR_LIMIT);
   localparam logic [c_werr_w-1:0] c_werr_one  = c_werr_w'(1);
   localparam logic [c_pos_w-1:0]  c_win_last  = c_pos_w'(WINDOW - 1);
   localparam logic [c_pos_w-1:0]  c_pos_one   = c_pos_w'(1);
   localparam logic [CNT_W-1:0]    c_cnt_one   = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_SYNC   = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   // Input synchroniser; en travels alongside so each strobe stays paired
   // with its own bit.
   logic sync1_q, sync1_d;
   logic d_s_q, d_s_d;
   logic en1_q, en1_d;
   logic en_s_q, en_s_d;

   state_t              state_q, state_d;
   logic [6:0]          sr_q, sr_d;
   logic [2:0]          fill_q, fill_d;
   logic [7:0]          good_q, good_d;
   logic [c_pos_w-1:0]  pos_q, pos_d;
   logic [c_werr_w-1:0] win_err_q, win_err_d;
   logic                locked_q, locked_d;
   logic                bit_err_q, bit_err_d;
   logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
   logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;

   logic                w_pred;
   logic                w_mismatch;
   logic [c_werr_w-1:0] w_werr_inc;

   // sr[0] is the newest bit, so the x^7+x^6 taps are the two oldest.
   assign w_pred     = sr_q[6] ^ sr_q[5];
   assign w_mismatch = d_s_q ^ w_pred;
   assign w_werr_inc = win_err_q + c_werr_one;

   always_comb begin
      sync1_d   = data_in;
      d_s_d     = sync1_q;
      en1_d     = en;
      en_s_d    = en1_q;

      state_d   = state_q;
      sr_d      = sr_q;
      fill_d    = fill_q;
      good_d    = good_q;
      pos_d     = pos_q;
      win_err_d = win_err_q;
      err_cnt_d = err_cnt_q;
      bit_cnt_d = bit_cnt_q;
      bit_err_d = 1'b0;

      if (en_s_q) begin
         case (state_q)
            ST_HUNT: begin
               sr_d = {sr_q[5:0], d_s_q};
               if (fill_q == 3'd6) begin
                  // Seventh bit: an all-zero register is the LFSR lock-up
                  // state and cannot seed the reference.
                  fill_d = 3'd0;
                  if (sr_d != 7'd0) begin
                     state_d = ST_SYNC;
                     good_d  = 8'd0;
                  end
               end else begin
                  fill_d = fill_q + 3'd1;
               end
            end

            ST_SYNC: begin
               if (!w_mismatch) begin
                  sr_d   = {sr_q[5:0], w_pred};
                  good_d = good_q + 8'd1;
                  if (good_d == c_sync_bits) begin
                     state_d = ST_LOCKED;
                  end
               end else begin
                  state_d = ST_HUNT;
                  fill_d  = 3'd0;
                  sr_d    = 7'd0;
               end
            end

            ST_LOCKED: begin
               // The reference free-runs on its own prediction so a line
               // error never corrupts it.
               sr_d = {sr_q[5:0], w_pred};
               if (bit_cnt_q != '1) begin
                  bit_cnt_d = bit_cnt_q + c_cnt_one;
               end
               if (w_mismatch) begin
                  bit_err_d = 1'b1;
                  if (err_cnt_q != '1) begin
                     err_cnt_d = err_cnt_q + c_cnt_one;
                  end
               end
               // Limit check on the current bit wins over the window wrap.
               if (w_mismatch && (w_werr_inc == c_err_limit)) begin
                  state_d   = ST_HUNT;
                  fill_d    = 3'd0;
                  sr_d      = 7'd0;
                  pos_d     = '0;
                  win_err_d = '0;
               end else if (pos_q == c_win_last) begin
                  pos_d     = '0;
                  win_err_d = '0;
               end else begin
                  pos_d = pos_q + c_pos_one;
                  if (w_mismatch) begin
                     win_err_d = w_werr_inc;
                  end
               end
            end

            default: begin
               state_d = ST_HUNT;
               fill_d  = 3'd0;
               sr_d    = 7'd0;
            end
         endcase
      end

      // Clear beats any same-cycle increment.
      if (clr_cnt) begin
         err_cnt_d = '0;
         bit_cnt_d = '0;
      end

      // Lock is asserted one edge after entering LOCKED and drops on the
      // same edge that leaves it.
      locked_d = (state_q == ST_LOCKED) && (state_d == ST_LOCKED);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q   <= 1'b0;
         d_s_q     <= 1'b0;
         en1_q     <= 1'b0;
         en_s_q    <= 1'b0;
         state_q   <= ST_HUNT;
         sr_q      <= 7'd0;
         fill_q    <= 3'd0;
         good_q    <= 8'd0;
         pos_q     <= '0;
         win_err_q <= '0;
         locked_q  <= 1'b0;
         bit_err_q <= 1'b0;
         err_cnt_q <= '0;
         bit_cnt_q <= '0;
      end else begin
         sync1_q   <= sync1_d;
         d_s_q     <= d_s_d;
         en1_q     <= en1_d;
         en_s_q    <= en_s_d;
         state_q   <= state_d;
         sr_q      <= sr_d;
         fill_q    <= fill_d;
         good_q    <= good_d;
         pos_q     <= pos_d;
         win_err_q <= win_err_d;
         locked_q  <= locked_d;
         bit_err_q <= bit_err_d;
         err_cnt_q <= err_cnt_d;
         bit_cnt_q <= bit_cnt_d;
      end
   end

   assign locked  = locked_q;
   assign bit_err = bit_err_q;
   assign err_cnt = err_cnt_q;
   assign bit_cnt = bit_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_prbs_rx_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_prbs_rx_checker
//  Purpose  : Self-checking bench for prbs_rx_checker. A behavioural model
//             built on bit queues predicts every output on every cycle;
//             scenario records and hand sequences check end values, latency
//             and corner cases; a second instance with a narrow counter
//             covers saturation.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_prbs_rx_checker;

   localparam int SYNC_BITS = 32;
   localparam int ERR_LIMIT = 8;
   localparam int WINDOW    = 256;
   localparam int CNT_W     = 16;
   localparam int SAT_W     = 4;
   localparam int CNT_MAX   = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst_n, data_in, en, clr_cnt;
   logic             locked, bit_err;
   logic [CNT_W-1:0] err_cnt, bit_cnt;
   logic             s_locked, s_bit_err;
   logic [SAT_W-1:0] s_err_cnt, s_bit_cnt;

   always #5 clk = ~clk;

   prbs_rx_checker #(
      .SYNC_BITS(SYNC_BITS), .ERR_LIMIT(ERR_LIMIT), .WINDOW(WINDOW), .CNT_W(CNT_W)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .en(en), .clr_cnt(clr_cnt),
      .locked(locked), .bit_err(bit_err), .err_cnt(err_cnt), .bit_cnt(bit_cnt)
   );

   prbs_rx_checker #(
      .SYNC_BITS(32), .ERR_LIMIT(32), .WINDOW(256), .CNT_W(SAT_W)
   ) u_sat (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .en(en), .clr_cnt(clr_cnt),
      .locked(s_locked), .bit_err(s_bit_err), .err_cnt(s_err_cnt), .bit_cnt(s_bit_cnt)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40) $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference (bit-stream level) -------------
   int m_mode;            // 0 hunting, 1 verifying, 2 locked
   bit m_ref[$];          // last <=7 reference bits, oldest first
   int m_fill, m_good, m_pos, m_werr, m_err, m_bits;
   bit m_locked, m_bit_err;
   bit pipe_d[$], pipe_e[$];

   task automatic model_reset();
      m_mode = 0; m_ref.delete();
      m_fill = 0; m_good = 0; m_pos = 0; m_werr = 0; m_err = 0; m_bits = 0;
      m_locked = 0; m_bit_err = 0;
      pipe_d.delete(); pipe_e.delete();
      repeat (2) begin pipe_d.push_back(1'b0); pipe_e.push_back(1'b0); end
   endtask

   task automatic model_edge(input bit d, input bit e, input bit c);
      bit pd, pe, p;
      int prev, ones;
      pipe_d.push_back(d); pipe_e.push_back(e);
      pd = pipe_d.pop_front(); pe = pipe_e.pop_front();
      prev = m_mode; m_bit_err = 0;
      if (pe) begin
         if (m_mode == 0) begin
            m_ref.push_back(pd);
            if (m_ref.size() > 7) void'(m_ref.pop_front());
            m_fill++;
            if (m_fill == 7) begin
               m_fill = 0; ones = 0;
               foreach (m_ref[i]) ones += int'(m_ref[i]);
               if (ones != 0) begin m_mode = 1; m_good = 0; end
            end
         end else begin
            p = m_ref[0] ^ m_ref[1];   // b[n] = b[n-7] ^ b[n-6]
            if (m_mode == 1) begin
               if (pd == p) begin
                  m_ref.push_back(p); void'(m_ref.pop_front());
                  m_good++;
                  if (m_good == SYNC_BITS) m_mode = 2;
               end else begin
                  m_mode = 0; m_fill = 0; m_ref.delete();
               end
            end else begin
               m_ref.push_back(p); void'(m_ref.pop_front());
               if (m_bits < CNT_MAX) m_bits++;
               m_pos++;
               if (pd != p) begin
                  m_bit_err = 1;
                  if (m_err < CNT_MAX) m_err++;
                  m_werr++;
               end
               if (m_werr == ERR_LIMIT) begin
                  m_mode = 0; m_fill = 0; m_werr = 0; m_pos = 0; m_ref.delete();
               end else if (m_pos == WINDOW) begin
                  m_werr = 0; m_pos = 0;
               end
            end
         end
      end
      if (c) begin m_err = 0; m_bits = 0; end
      m_locked = (prev == 2) && (m_mode == 2);
   endtask

   // ---------------- PRBS-7 source ----------------------------------------
   logic [6:0] g_seed;
   int         g_cnt;
   bit         g_hist[$];

   task automatic gen_start(input logic [6:0] seed);
      g_seed = seed; g_cnt = 0; g_hist.delete();
   endtask

   task automatic gen_next(output bit b);
      if (g_cnt < 7) b = g_seed[6 - g_cnt];
      else           b = g_hist[0] ^ g_hist[1];
      g_hist.push_back(b);
      if (g_hist.size() > 7) void'(g_hist.pop_front());
      g_cnt++;
   endtask

   // ---------------- drivers (entered and left at posedge + 1) -----------
   task automatic cycle(input bit d, input bit e, input bit c);
      data_in = d; en = e; clr_cnt = c;
      @(posedge clk);
      model_edge(d, e, c);
      #1;
      check("cycle", {locked, bit_err, err_cnt, bit_cnt},
            {m_locked, m_bit_err, CNT_W'(m_err), CNT_W'(m_bits)});
   endtask

   task automatic send_bit(input bit b, input bit tog);
      if (tog) cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      cycle(b, 1'b1, 1'b0);
   endtask

   task automatic flush(input int n);
      repeat (n) cycle(1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      data_in = 1'b0; en = 1'b0; clr_cnt = 1'b0;
      rst_n = 1'b0;
      model_reset();
      #2;
      check("reset", {locked, bit_err, err_cnt, bit_cnt, s_locked, s_bit_err, s_err_cnt, s_bit_cnt}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cycle(1'b0, 1'b0, 1'b0);
   endtask

   // ---------------- scenario table ---------------------------------------
   typedef struct {
      string      name;
      logic [6:0] seed;
      int         lead;      // clean bits before the first flip
      int         n_flips;
      int         spacing;   // bits between flips
      int         tail;      // clean bits after the flip region
      bit         en_tog;    // idle en=0 cycle before every bit
      bit         exp_locked;
      int         exp_err;
      int         exp_bits;
   } vec_t;

   vec_t vecs[6];

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit b, e, c, r1, r2, r3, r4;
      int total, lock_at;

      vecs[0] = '{"clean",    7'h7F,  39,  0,  1, 1000, 1'b0, 1'b1,  0, 1000};
      vecs[1] = '{"iso3",     7'h13, 100,  3, 50,  100, 1'b0, 1'b1,  3,  311};
      vecs[2] = '{"drop8",    7'h5A,  60,  8, 10,  100, 1'b0, 1'b1,  8,  162};
      vecs[3] = '{"seven_pw", 7'h21,  40, 14, 37,   50, 1'b0, 1'b1, 14,  569};
      vecs[4] = '{"en_tog",   7'h55,  39,  0,  1,  100, 1'b1, 1'b1,  0,  100};
      vecs[5] = '{"zeros",    7'h00, 200,  0,  1,    0, 1'b0, 1'b0,  0,    0};

      rst_n = 1'b0; data_in = 1'b0; en = 1'b0; clr_cnt = 1'b0;
      model_reset();
      @(posedge clk);
      #1;

      foreach (vecs[i]) begin
         do_reset();
         gen_start(vecs[i].seed);
         total = vecs[i].lead + vecs[i].n_flips * vecs[i].spacing + vecs[i].tail;
         for (int n = 0; n < total; n++) begin
            bit f;
            gen_next(b);
            f = (n >= vecs[i].lead) && (n < vecs[i].lead + vecs[i].n_flips * vecs[i].spacing)
                && (((n - vecs[i].lead) % vecs[i].spacing) == 0);
            send_bit(b ^ f, vecs[i].en_tog);
         end
         flush(3);
         check({vecs[i].name, "_locked"},  locked,  vecs[i].exp_locked);
         check({vecs[i].name, "_err_cnt"}, err_cnt, vecs[i].exp_err);
         check({vecs[i].name, "_bit_cnt"}, bit_cnt, vecs[i].exp_bits);
      end

      // Lock latency, then isolated errors and their 3-clk latency.
      do_reset();
      gen_start(7'h3C);
      lock_at = 0;
      for (int n = 1; n <= 100; n++) begin
         gen_next(b);
         cycle(b, 1'b1, 1'b0);
         if (locked === 1'b1 && lock_at == 0) lock_at = n;
      end
      check("lock_latency", lock_at, 42);
      for (int k = 0; k < 3; k++) begin
         gen_next(b); cycle(~b, 1'b1, 1'b0); r1 = bit_err;
         gen_next(b); cycle(b, 1'b1, 1'b0);  r2 = bit_err;
         gen_next(b); cycle(b, 1'b1, 1'b0);  r3 = bit_err;
         gen_next(b); cycle(b, 1'b1, 1'b0);  r4 = bit_err;
         check("bit_err_latency", {r1, r2, r3, r4}, 4'b0010);
         repeat (20) begin gen_next(b); cycle(b, 1'b1, 1'b0); end
      end
      repeat (50) begin gen_next(b); cycle(b, 1'b1, 1'b0); end
      check("iso_err_cnt", err_cnt, 3);
      check("iso_locked", locked, 1);

      // Stuck-at-zero input, then a real stream.
      do_reset();
      repeat (200) cycle(1'b0, 1'b1, 1'b0);
      check("zero_state", {locked, err_cnt, bit_cnt}, 33'd0);
      gen_start(7'h11);
      repeat (100) begin gen_next(b); cycle(b, 1'b1, 1'b0); end
      check("zero_then_prbs_locked", locked, 1);

      // One-bit phase slip during verification.
      do_reset();
      gen_start(7'h2D);
      repeat (20) begin gen_next(b); cycle(b, 1'b1, 1'b0); end
      gen_next(b);
      repeat (19) begin gen_next(b); cycle(b, 1'b1, 1'b0); end
      flush(3);
      check("slip_no_lock", locked, 0);
      lock_at = 0;
      for (int n = 1; n <= 200 && lock_at == 0; n++) begin
         gen_next(b); cycle(b, 1'b1, 1'b0);
         if (locked === 1'b1) lock_at = n;
      end
      check("slip_relock", (lock_at != 0), 1);

      // Strobed input: lock needs exactly 39 enabled bits.
      do_reset();
      gen_start(7'h55);
      repeat (38) begin gen_next(b); send_bit(b, 1'b1); end
      flush(4);
      check("tog_38_bits", locked, 0);
      gen_next(b); send_bit(b, 1'b1);
      flush(4);
      check("tog_39_bits", locked, 1);

      // Saturation, clear-vs-increment priority, async reset while locked.
      do_reset();
      gen_start(7'h6B);
      repeat (40) begin gen_next(b); cycle(b, 1'b1, 1'b0); end
      repeat (20) begin
         gen_next(b); cycle(~b, 1'b1, 1'b0);
         gen_next(b); cycle(b, 1'b1, 1'b0);
         gen_next(b); cycle(b, 1'b1, 1'b0);
      end
      flush(3);
      check("sat_err_cnt", s_err_cnt, 15);
      check("sat_bit_cnt", s_bit_cnt, 15);
      check("sat_locked", s_locked, 1);
      gen_next(b); cycle(~b, 1'b1, 1'b0);
      gen_next(b); cycle(b, 1'b1, 1'b0);
      gen_next(b); cycle(b, 1'b1, 1'b1);
      check("clr_vs_err", {s_bit_err, s_err_cnt, s_bit_cnt}, 9'h100);
      check("pre_rst_locked", s_locked, 1);
      do_reset();

      // Randomised stream: strobes, flips, slips and clears.
      gen_start(7'($urandom_range(1, 127)));
      for (int n = 0; n < 4000; n++) begin
         e = ($urandom_range(0, 3) != 0);
         c = ($urandom_range(0, 299) == 0);
         if (e) begin
            if ($urandom_range(0, 499) == 0) gen_next(b);
            gen_next(b);
            if ($urandom_range(0, 79) == 0) b = ~b;
         end else begin
            b = 1'($urandom_range(0, 1));
         end
         cycle(b, e, c);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
